sata_regfis_host: RTL and testbench

//  Host-side command initiator for the SATA transport layer.
//  - Accepts one ATA command request and serialises it as a 5-word Host-to-Device

---
 rtl/sata_regfis_host.sv | 196 +++++++++++++++++++
 tb/tb_sata_regfis_host.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_regfis_host.sv
// SATA host command initiator: sends one H2D Register FIS per command and
// parses the D2H Register FIS reply into status/error/LBA/count.
module sata_regfis_host #(
  parameter int         LGTIMEOUT    = 20,
  parameter logic [3:0] PMPORT       = 4'h0,
  parameter bit         OPT_LOWPOWER = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_cmd_command,
  input  logic [15:0] i_cmd_features,
  input  logic [47:0] i_cmd_lba,
  input  logic [15:0] i_cmd_count,
  input  logic [7:0]  i_cmd_device,
  input  logic [7:0]  i_cmd_control,
  input  logic [7:0]  i_cmd_icc,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        s_abort,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_fail,
  output logic [7:0]  o_status,
  output logic [7:0]  o_error,
  output logic [47:0] o_lba,
  output logic [15:0] o_count
);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  localparam logic [LGTIMEOUT-1:0] TONE  = 1;
  localparam logic [LGTIMEOUT-1:0] TLAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

  state_t state_q, state_d;
  logic [7:0]  cmd_q, dev_q, ctl_q, icc_q;
  logic [15:0] feat_q, cnt_q;
  logic [47:0] lba_q;
  logic [2:0]  w_q, r_q;
  logic [31:0] mdata_q;
  logic        mlast_q, disc_q;
  logic [LGTIMEOUT-1:0] timer_q;
  logic [7:0]  cap_err_q, cap_err_d, cap_st_q, cap_st_d;
  logic [47:0] cap_lba_q, cap_lba_d;
  logic [15:0] cap_cnt_q, cap_cnt_d;
  logic        done_q;
  logic [1:0]  fail_q;
  logic [7:0]  status_q, error_q;
  logic [47:0] olba_q;
  logic [15:0] ocnt_q;

  function automatic logic [31:0] fis_word(input logic [2:0] idx, input logic [7:0] cmd,
      input logic [15:0] feat, input logic [47:0] lba, input logic [15:0] cnt,
      input logic [7:0] dev, input logic [7:0] ctl, input logic [7:0] icc);
    case (idx)
      3'd0:    fis_word = {feat[7:0], cmd, 1'b1, 3'b000, PMPORT, 8'h27};
      3'd1:    fis_word = {dev, lba[23:0]};
      3'd2:    fis_word = {feat[15:8], lba[47:24]};
      3'd3:    fis_word = {ctl, icc, cnt};
      default: fis_word = 32'h0;
    endcase
  endfunction

  logic accept, hs, hs_end, in_wait, rx, type_bad, fin, fin_ok, tmo;
  assign accept   = (state_q == S_IDLE) && i_cmd_valid;
  assign hs       = (state_q == S_SEND) && m_ready;
  assign hs_end   = hs && (w_q == 3'd4);
  assign in_wait  = (state_q == S_WAIT);
  assign rx       = in_wait && s_valid && !s_abort && !disc_q;
  assign type_bad = rx && (r_q == 3'd0) && (s_data[7:0] != 8'h34);
  assign fin      = rx && s_last && !type_bad;
  assign fin_ok   = fin && (r_q == 3'd4);
  // A final word landing on the timeout cycle wins over the timeout
  assign tmo      = in_wait && (timer_q == TLAST) && !fin;

  always_comb begin
    cap_err_d = cap_err_q;
    cap_st_d  = cap_st_q;
    cap_lba_d = cap_lba_q;
    cap_cnt_d = cap_cnt_q;
    if (rx && !type_bad) begin
      case (r_q)
        3'd0: begin cap_err_d = s_data[31:24]; cap_st_d = s_data[23:16]; end
        3'd1: cap_lba_d[23:0]  = s_data[23:0];
        3'd2: cap_lba_d[47:24] = s_data[23:0];
        3'd3: cap_cnt_d = s_data[15:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SEND;
      S_SEND:  if (hs_end) state_d = S_WAIT;
      S_WAIT:  if (fin || tmo) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = (state_q == S_IDLE);
    o_busy      = (state_q != S_IDLE);
    m_valid     = (state_q == S_SEND);
  end

  assign m_data   = (OPT_LOWPOWER && !m_valid) ? 32'h0 : mdata_q;
  assign m_last   = m_valid && mlast_q;
  assign o_done   = done_q;
  assign o_fail   = fail_q;
  assign o_status = status_q;
  assign o_error  = error_q;
  assign o_lba    = olba_q;
  assign o_count  = ocnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cmd_q <= '0; dev_q <= '0; ctl_q <= '0; icc_q <= '0;
      feat_q <= '0; cnt_q <= '0; lba_q <= '0;
      w_q <= '0; mdata_q <= '0; mlast_q <= 1'b0;
    end else if (accept) begin
      cmd_q <= i_cmd_command; feat_q <= i_cmd_features; lba_q <= i_cmd_lba;
      cnt_q <= i_cmd_count; dev_q <= i_cmd_device; ctl_q <= i_cmd_control;
      icc_q <= i_cmd_icc;
      w_q <= '0; mlast_q <= 1'b0;
      mdata_q <= fis_word(3'd0, i_cmd_command, i_cmd_features, i_cmd_lba,
                          i_cmd_count, i_cmd_device, i_cmd_control, i_cmd_icc);
    end else if (hs) begin
      if (hs_end) begin
        w_q <= '0; mdata_q <= '0; mlast_q <= 1'b0;
      end else begin
        w_q     <= w_q + 3'd1;
        mlast_q <= (w_q == 3'd3);
        mdata_q <= fis_word(w_q + 3'd1, cmd_q, feat_q, lba_q, cnt_q, dev_q, ctl_q, icc_q);
      end
    end
  end

  // Response tracking: disc_q swallows a foreign frame up to its s_last
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      timer_q <= '0; r_q <= '0; disc_q <= 1'b0;
      cap_err_q <= '0; cap_st_q <= '0; cap_lba_q <= '0; cap_cnt_q <= '0;
    end else if (hs_end) begin
      timer_q <= '0; r_q <= '0; disc_q <= 1'b0;
    end else if (in_wait) begin
      timer_q   <= timer_q + TONE;
      cap_err_q <= cap_err_d; cap_st_q <= cap_st_d;
      cap_lba_q <= cap_lba_d; cap_cnt_q <= cap_cnt_d;
      if (s_abort) begin
        r_q <= '0; disc_q <= 1'b0;
      end else if (s_valid) begin
        if (disc_q) begin
          if (s_last) begin r_q <= '0; disc_q <= 1'b0; end
        end else if (type_bad) begin
          r_q <= '0; disc_q <= !s_last;
        end else if (s_last) begin
          r_q <= '0;
        end else if (r_q != 3'd7) begin
          r_q <= r_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      done_q <= 1'b0; fail_q <= '0; status_q <= '0; error_q <= '0;
      olba_q <= '0; ocnt_q <= '0;
    end else begin
      done_q <= fin || tmo;
      if (fin) begin
        fail_q   <= fin_ok ? 2'd0 : 2'd2;
        status_q <= cap_st_d;
        error_q  <= cap_err_d;
        if (fin_ok) begin
          olba_q <= cap_lba_d;
          ocnt_q <= cap_cnt_d;
        end
      end else if (tmo) begin
        fail_q <= 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_sata_regfis_host.sv
// Directed bench for sata_regfis_host: FIS serialisation, stalls, timeout,
// short/foreign/aborted responses and asynchronous reset mid-frame.
module tb_sata_regfis_host;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd_command = '0;
  logic [15:0] i_cmd_features = '0;
  logic [47:0] i_cmd_lba = '0;
  logic [15:0] i_cmd_count = '0;
  logic [7:0]  i_cmd_device = '0, i_cmd_control = '0, i_cmd_icc = '0;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        s_valid = 1'b0, s_last = 1'b0, s_abort = 1'b0;
  logic [31:0] s_data = '0;
  logic        o_busy, o_done;
  logic [1:0]  o_fail;
  logic [7:0]  o_status, o_error;
  logic [47:0] o_lba;
  logic [15:0] o_count;

  int vecs = 0;
  int errs = 0;

  sata_regfis_host #(.LGTIMEOUT(6), .PMPORT(4'h0), .OPT_LOWPOWER(1'b0)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_command(i_cmd_command), .i_cmd_features(i_cmd_features),
    .i_cmd_lba(i_cmd_lba), .i_cmd_count(i_cmd_count),
    .i_cmd_device(i_cmd_device), .i_cmd_control(i_cmd_control), .i_cmd_icc(i_cmd_icc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_abort(s_abort),
    .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail),
    .o_status(o_status), .o_error(o_error), .o_lba(o_lba), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk); #1;
  endtask

  task automatic issue(input logic [7:0] cmd, input logic [15:0] feat, input logic [47:0] lba,
                       input logic [15:0] cnt, input logic [7:0] dev, input logic [7:0] ctl,
                       input logic [7:0] icc);
    i_cmd_valid = 1'b1; i_cmd_command = cmd; i_cmd_features = feat; i_cmd_lba = lba;
    i_cmd_count = cnt; i_cmd_device = dev; i_cmd_control = ctl; i_cmd_icc = icc;
    tick;
    i_cmd_valid = 1'b0;
  endtask

  task automatic rx(input logic [31:0] d, input logic last, input logic abort);
    s_valid = 1'b1; s_data = d; s_last = last; s_abort = abort;
    tick;
    s_valid = 1'b0; s_last = 1'b0; s_abort = 1'b0; s_data = '0;
  endtask

  task automatic test_reset;
    repeat (2) tick;
    vecs++;
    if (o_cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", o_cmd_ready); end
    vecs++;
    if ({m_valid, m_last, o_busy, o_done, o_fail} !== 6'b0) begin
      errs++; $display("FAIL reset_ctl: got %b want 000000", {m_valid, m_last, o_busy, o_done, o_fail});
    end
    vecs++;
    if ({m_data, o_status, o_error, o_lba, o_count} !== 112'h0) begin
      errs++; $display("FAIL reset_data: got %h want 0", {m_data, o_status, o_error, o_lba, o_count});
    end
    i_reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [31:0] exp [5];
    exp = '{32'h00258027, 32'h40345678, 32'h00000012, 32'h00000008, 32'h00000000};
    m_ready = 1'b1;
    issue(8'h25, 16'h0, 48'h000012345678, 16'd8, 8'h40, 8'h0, 8'h0);
    for (int k = 0; k < 5; k++) begin
      vecs++;
      if ({m_valid, m_last, m_data} !== {1'b1, (k == 4), exp[k]}) begin
        errs++; $display("FAIL basic_dw%0d: got v=%b l=%b %h want v=1 l=%b %h",
                         k, m_valid, m_last, m_data, (k == 4), exp[k]);
      end
      tick;
    end
    vecs++;
    if ({m_valid, o_busy, o_cmd_ready} !== 3'b010) begin
      errs++; $display("FAIL basic_wait: got %b want 010", {m_valid, o_busy, o_cmd_ready});
    end
    rx(32'h00500034, 1'b0, 1'b0); rx(32'h0, 1'b0, 1'b0); rx(32'h0, 1'b0, 1'b0);
    rx(32'h0, 1'b0, 1'b0); rx(32'h0, 1'b1, 1'b0);
    vecs++;
    if ({o_done, o_cmd_ready, o_fail, o_status, o_error} !== {1'b1, 1'b1, 2'd0, 8'h50, 8'h00}) begin
      errs++; $display("FAIL basic_done: got %b %b %0d %h %h want 1 1 0 50 00",
                       o_done, o_cmd_ready, o_fail, o_status, o_error);
    end
    tick;
    vecs++;
    if (o_done !== 1'b0) begin errs++; $display("FAIL basic_pulse: got %b want 0", o_done); end
  endtask

  task automatic test_stall;
    logic [31:0] exp [5];
    int k;
    exp = '{32'hCDC88027, 32'hE0332211, 32'hAB665544, 32'h08110102, 32'h00000000};
    k = 0;
    issue(8'hC8, 16'hABCD, 48'h665544332211, 16'h0102, 8'hE0, 8'h08, 8'h11);
    for (int c = 0; c < 20 && k < 5; c++) begin
      m_ready = (c % 2 == 1);
      vecs++;
      if ({m_valid, m_last, m_data} !== {1'b1, (k == 4), exp[k]}) begin
        errs++; $display("FAIL stall_c%0d: got v=%b l=%b %h want v=1 l=%b %h",
                         c, m_valid, m_last, m_data, (k == 4), exp[k]);
      end
      tick;
      if (m_ready) k++;
    end
    m_ready = 1'b1;
    vecs++;
    if (k !== 5 || m_valid !== 1'b0) begin
      errs++; $display("FAIL stall_end: got words=%0d v=%b want 5 0", k, m_valid);
    end
    rx(32'h01580034, 1'b0, 1'b0); rx(32'h00AABBCC, 1'b0, 1'b0); rx(32'h00112233, 1'b0, 1'b0);
    rx(32'h00000010, 1'b0, 1'b0); rx(32'h0, 1'b1, 1'b0);
    vecs++;
    if ({o_done, o_fail, o_status, o_error, o_lba, o_count} !==
        {1'b1, 2'd0, 8'h58, 8'h01, 48'h112233AABBCC, 16'h0010}) begin
      errs++; $display("FAIL stall_resp: got %b %0d %h %h %h %h want 1 0 58 01 112233aabbcc 0010",
                       o_done, o_fail, o_status, o_error, o_lba, o_count);
    end
    tick;
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    issue(8'hE7, 16'h0, 48'h0, 16'h0, 8'h0, 8'h0, 8'h0);
    repeat (5) tick;
    for (int c = 0; c < 100; c++) begin
      tick;
      n++;
      if (o_done) break;
    end
    vecs++;
    if (o_done !== 1'b1 || n !== 63) begin
      errs++; $display("FAIL timeout_cycles: got done=%b after %0d want done=1 after 63", o_done, n);
    end
    vecs++;
    if ({o_fail, o_status, o_error, o_lba} !== {2'd1, 8'h58, 8'h01, 48'h112233AABBCC}) begin
      errs++; $display("FAIL timeout_hold: got %0d %h %h %h want 1 58 01 112233aabbcc",
                       o_fail, o_status, o_error, o_lba);
    end
    tick;
  endtask

  task automatic test_bad_length;
    issue(8'h25, 16'h0, 48'h1, 16'd1, 8'h40, 8'h0, 8'h0);
    repeat (5) tick;
    rx(32'h04510034, 1'b0, 1'b0); rx(32'h00999999, 1'b0, 1'b0); rx(32'h00777777, 1'b1, 1'b0);
    vecs++;
    if ({o_done, o_fail, o_status, o_error} !== {1'b1, 2'd2, 8'h51, 8'h04}) begin
      errs++; $display("FAIL badlen_done: got %b %0d %h %h want 1 2 51 04",
                       o_done, o_fail, o_status, o_error);
    end
    vecs++;
    if ({o_lba, o_count} !== {48'h112233AABBCC, 16'h0010}) begin
      errs++; $display("FAIL badlen_hold: got %h %h want 112233aabbcc 0010", o_lba, o_count);
    end
    tick;
  endtask

  task automatic test_abort_foreign;
    issue(8'h25, 16'h0, 48'h2, 16'd1, 8'h40, 8'h0, 8'h0);
    repeat (5) tick;
    rx(32'h00000041, 1'b0, 1'b0); rx(32'h00000001, 1'b0, 1'b0); rx(32'h00000002, 1'b1, 1'b0);
    vecs++;
    if ({o_done, o_busy} !== 2'b01) begin
      errs++; $display("FAIL foreign_ignored: got done=%b busy=%b want 0 1", o_done, o_busy);
    end
    rx(32'h00500034, 1'b0, 1'b0); rx(32'h00000001, 1'b0, 1'b0); rx(32'h00000002, 1'b0, 1'b1);
    vecs++;
    if ({o_done, o_busy} !== 2'b01) begin
      errs++; $display("FAIL abort_ignored: got done=%b busy=%b want 0 1", o_done, o_busy);
    end
    rx(32'h00500034, 1'b0, 1'b0); rx(32'h00000005, 1'b0, 1'b0); rx(32'h00000000, 1'b0, 1'b0);
    rx(32'h00000003, 1'b0, 1'b0); rx(32'h00000000, 1'b1, 1'b0);
    vecs++;
    if ({o_done, o_fail, o_status, o_error, o_lba, o_count} !==
        {1'b1, 2'd0, 8'h50, 8'h00, 48'h000000000005, 16'h0003}) begin
      errs++; $display("FAIL abort_good: got %b %0d %h %h %h %h want 1 0 50 00 000000000005 0003",
                       o_done, o_fail, o_status, o_error, o_lba, o_count);
    end
    tick;
  endtask

  task automatic test_reset_mid_send;
    issue(8'h25, 16'h0, 48'h000012345678, 16'd8, 8'h40, 8'h0, 8'h0);
    tick; tick;
    vecs++;
    if ({m_valid, m_data} !== {1'b1, 32'h00000012}) begin
      errs++; $display("FAIL rst_pre: got %b %h want 1 00000012", m_valid, m_data);
    end
    i_reset = 1'b1;
    #1;
    vecs++;
    if ({m_valid, m_last, o_cmd_ready, o_busy} !== 4'b0010) begin
      errs++; $display("FAIL rst_async: got %b want 0010", {m_valid, m_last, o_cmd_ready, o_busy});
    end
    vecs++;
    if ({o_status, o_lba} !== 56'h0) begin
      errs++; $display("FAIL rst_clear: got %h %h want 0 0", o_status, o_lba);
    end
    tick;
    i_reset = 1'b0;
    tick;
    issue(8'h35, 16'h0, 48'h0, 16'd1, 8'h40, 8'h0, 8'h0);
    vecs++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 32'h00358027}) begin
      errs++; $display("FAIL rst_restart: got %b %b %h want 1 0 00358027", m_valid, m_last, m_data);
    end
    repeat (5) tick;
    rx(32'h00500034, 1'b0, 1'b0); rx(32'h0, 1'b0, 1'b0); rx(32'h0, 1'b0, 1'b0);
    rx(32'h0, 1'b0, 1'b0); rx(32'h0, 1'b1, 1'b0);
    vecs++;
    if ({o_done, o_fail, o_status} !== {1'b1, 2'd0, 8'h50}) begin
      errs++; $display("FAIL rst_resp: got %b %0d %h want 1 0 50", o_done, o_fail, o_status);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_timeout;
    test_bad_length;
    test_abort_foreign;
    test_reset_mid_send;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
